// File: rtl/fetch_queue.sv
// Instruction-fetch unit: owns the PC, issues word fetches to a 1-cycle imem and buffers {pc, instr} in a queue.
// Define FETCHQ_STATS_EN to build the stat_fetched / stat_flushed counters; otherwise they read 0.
module fetch_queue #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [DATA_W-1:0] HALT_WORD = {DATA_W{1'b1}},
  parameter int                FIN_DELAY = 7,
  parameter int                CNT_W     = 16
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic [ADDR_W-1:0] out_pc4,
  output logic              fin,
  output logic [CNT_W-1:0]  stat_fetched,
  output logic [CNT_W-1:0]  stat_flushed,
  output logic [1:0]        dbg_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CQ_W  = PTR_W + 1;
  localparam int OCC_W = PTR_W + 2;
  localparam int DC_W  = $clog2(FIN_DELAY + 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] RST_PC     = RESET_PC & ALIGN_MASK;
  localparam logic [OCC_W-1:0]  DEPTH_L    = OCC_W'(DEPTH);
  localparam logic [DC_W-1:0]   DC_LAST    = DC_W'(FIN_DELAY - 1);

  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_DRAIN = 2'd1, ST_DONE = 2'd2} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] fetch_pc, infl_pc;
  logic              inflight;
  logic [PTR_W-1:0]  head, tail;
  logic [CQ_W-1:0]   count;
  logic [DC_W-1:0]   drain_cnt;
  logic [ADDR_W-1:0] mem_pc    [DEPTH];
  logic [DATA_W-1:0] mem_instr [DEPTH];

  logic             redir_act, pop, resp_valid, is_halt, push, drain_done;
  logic [OCC_W-1:0] occ;

  // Handshake: the head transfers on a cycle where out_valid && out_ready at posedge;
  // the head stays stable while out_valid && !out_ready.
  always_comb begin
    redir_act  = redirect && (state != ST_DONE);
    pop        = out_valid && out_ready;
    resp_valid = inflight && !redir_act;
    is_halt    = resp_valid && (state == ST_RUN) && (imem_data == HALT_WORD);
    push       = resp_valid && (state == ST_RUN) && !is_halt;
    occ        = OCC_W'(count) + OCC_W'(inflight);
    drain_done = (state == ST_DRAIN) && !redir_act && (count == '0) && (drain_cnt == DC_LAST);
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) state <= ST_RUN;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_RUN:   if (!redir_act && is_halt) state_nx = ST_DRAIN;
      ST_DRAIN: if (redir_act)             state_nx = ST_RUN;
                else if (drain_done)       state_nx = ST_DONE;
      default:  state_nx = ST_DONE;
    endcase
  end

  // Reset also masks the request so nothing is issued while RESET_N is low.
  always_comb begin
    imem_req  = RESET_N && (state == ST_RUN) && !redirect && (occ < DEPTH_L);
    imem_addr = fetch_pc;
    out_valid = (count != '0);
    out_instr = mem_instr[head];
    out_pc    = mem_pc[head];
    out_pc4   = mem_pc[head] + ADDR_W'(4);
    dbg_state = state;
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      fetch_pc  <= RST_PC;
      inflight  <= 1'b0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      drain_cnt <= '0;
      fin       <= 1'b0;
    end else if (redir_act) begin
      fetch_pc  <= redirect_pc & ALIGN_MASK;
      inflight  <= 1'b0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      drain_cnt <= '0;
    end else begin
      if (imem_req) fetch_pc <= fetch_pc + ADDR_W'(4);
      inflight <= imem_req;
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      count <= count + CQ_W'(push) - CQ_W'(pop);
      if ((state == ST_DRAIN) && (count == '0)) drain_cnt <= drain_cnt + DC_W'(1);
      if (drain_done) fin <= 1'b1;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (imem_req) infl_pc <= fetch_pc;
    if (push) begin
      mem_pc[tail]    <= infl_pc;
      mem_instr[tail] <= imem_data;
    end
  end

`ifdef FETCHQ_STATS_EN
  localparam int SUM_W = CNT_W + OCC_W;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  logic [CNT_W-1:0] fetched_q, flushed_q;
  logic [OCC_W-1:0] flush_amt;
  logic [SUM_W-1:0] flush_sum;

  always_comb begin
    flush_amt = OCC_W'(count) - OCC_W'(pop) + OCC_W'(inflight);
    flush_sum = SUM_W'(flushed_q) + SUM_W'(flush_amt);
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      fetched_q <= '0;
      flushed_q <= '0;
    end else begin
      if (push && (fetched_q != {CNT_W{1'b1}})) fetched_q <= fetched_q + CNT_W'(1);
      if (redir_act) flushed_q <= (flush_sum > CNT_MAX) ? {CNT_W{1'b1}} : flush_sum[CNT_W-1:0];
    end
  end

  assign stat_fetched = fetched_q;
  assign stat_flushed = flushed_q;
`else
  assign stat_fetched = '0;
  assign stat_flushed = '0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a 1-cycle memory model returns addr>>2 (or HALT_WORD at a chosen address);
// delivered entries are checked by a monitor against a queue of hand-computed {pc, instr} pairs.
`timescale 1ns/1ps
module tb_fetch_queue;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int DEPTH     = 4;
  localparam int FIN_DELAY = 7;
  localparam int CNT_W     = 16;
  localparam logic [31:0] RESET_PC  = 32'h0;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [1:0]  ST_RUN = 2'd0, ST_DRAIN = 2'd1, ST_DONE = 2'd2;
`ifdef FETCHQ_STATS_EN
  localparam int STATS_ON = 1;
`else
  localparam int STATS_ON = 0;
`endif

  logic              CLOCK, RESET_N;
  logic              imem_req, redirect, out_valid, out_ready, fin;
  logic [ADDR_W-1:0] imem_addr, redirect_pc, out_pc, out_pc4;
  logic [DATA_W-1:0] imem_data, out_instr;
  logic [CNT_W-1:0]  stat_fetched, stat_flushed;
  logic [1:0]        dbg_state;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_pop_cyc = 0;
  int t0, t_empty, t_fin;

  logic [63:0] exp_q[$];
  logic [63:0] mon_e;
  logic [31:0] mem_q;
  logic        halt_en;
  logic [31:0] halt_addr;

  fetch_queue #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC),
    .HALT_WORD(HALT_WORD), .FIN_DELAY(FIN_DELAY), .CNT_W(CNT_W)
  ) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_pc4(out_pc4), .fin(fin),
    .stat_fetched(stat_fetched), .stat_flushed(stat_flushed), .dbg_state(dbg_state)
  );

  // clock / reset
  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;
  always @(posedge CLOCK) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // instruction memory with one cycle of latency
  always @(posedge CLOCK)
    if (imem_req) mem_q <= (halt_en && imem_addr == halt_addr) ? HALT_WORD : (imem_addr >> 2);
  assign imem_data = mem_q;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic expect_entry(input logic [31:0] pc, input logic [31:0] ins);
    exp_q.push_back({pc, ins});
  endtask

  // scoreboard monitor
  always @(negedge CLOCK) begin
    if (RESET_N && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pop: got pc %0h, required no entry", out_pc);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_pc", 64'(out_pc), 64'(mon_e[63:32]));
        check("out_instr", 64'(out_instr), 64'(mon_e[31:0]));
        check("out_pc4", 64'(out_pc4), 64'(mon_e[63:32] + 32'd4));
        last_pop_cyc = cyc;
      end
    end
  end

  // driver tasks
  task automatic do_reset(input logic rdy);
    @(posedge CLOCK); #1;
    RESET_N = 1'b0; out_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    @(posedge CLOCK);
    @(negedge CLOCK);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_imem_req", 64'(imem_req), 64'd0);
    check("rst_fin", 64'(fin), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_RUN));
    @(posedge CLOCK); #1;
    RESET_N = 1'b1; out_ready = rdy;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge CLOCK); #1;
      n++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    out_ready = 1'b0;
  endtask

  initial begin
    RESET_N = 1'b0; out_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    halt_en = 1'b0; halt_addr = 32'h0;

    // streaming, out_ready held high
    do_reset(1'b1);
    for (int i = 0; i < 8; i++) expect_entry(32'(i * 4), 32'(i));
    @(negedge CLOCK);
    check("first_req", 64'(imem_req), 64'd1);
    check("first_addr", 64'(imem_addr), 64'(RESET_PC));
    check("lat_valid_c0", 64'(out_valid), 64'd0);
    @(negedge CLOCK);
    check("lat_valid_c1", 64'(out_valid), 64'd0);
    @(negedge CLOCK);
    check("lat_valid_c2", 64'(out_valid), 64'd1);
    t0 = cyc;
    wait_drain(40);
    check("stream_gapless", 64'(last_pop_cyc - t0), 64'd7);

    // back-pressure: queue fills, head holds, then drains in order
    do_reset(1'b0);
    repeat (8) @(negedge CLOCK);
    check("full_req", 64'(imem_req), 64'd0);
    check("full_valid", 64'(out_valid), 64'd1);
    check("full_head_pc", 64'(out_pc), 64'h0);
    check("full_head_instr", 64'(out_instr), 64'h0);
    repeat (2) @(negedge CLOCK);
    check("hold_head_pc", 64'(out_pc), 64'h0);
    for (int i = 0; i < 5; i++) expect_entry(32'(i * 4), 32'(i));
    @(posedge CLOCK); #1;
    out_ready = 1'b1;
    @(negedge CLOCK);
    t0 = cyc;
    wait_drain(40);
    check("bp_gapless", 64'(last_pop_cyc - t0), 64'd4);

    // redirect with 3 queued entries and one fetch in flight
    do_reset(1'b0);
    repeat (4) @(posedge CLOCK);
    #1;
    redirect = 1'b1; redirect_pc = 32'h43;
    @(negedge CLOCK);
    check("redir_no_req", 64'(imem_req), 64'd0);
    @(posedge CLOCK); #1;
    redirect = 1'b0;
    @(negedge CLOCK);
    check("redir_valid", 64'(out_valid), 64'd0);
    check("redir_req", 64'(imem_req), 64'd1);
    check("redir_addr", 64'(imem_addr), 64'h40);
    check("stat_fetched", 64'(stat_fetched), STATS_ON ? 64'd3 : 64'd0);
    check("stat_flushed", 64'(stat_flushed), STATS_ON ? 64'd4 : 64'd0);
    for (int i = 0; i < 3; i++) expect_entry(32'h40 + 32'(i * 4), 32'h10 + 32'(i));
    @(posedge CLOCK); #1;
    out_ready = 1'b1;
    wait_drain(40);

    // halt sentinel at 0x0C, fin after the drain delay, sticky under redirect
    halt_en = 1'b1; halt_addr = 32'h0C;
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) expect_entry(32'(i * 4), 32'(i));
    t_empty = -1; t_fin = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLOCK);
      if (t_empty < 0 && dbg_state == ST_DRAIN && !out_valid) begin
        t_empty = cyc;
        check("drain_no_req", 64'(imem_req), 64'd0);
      end
      if (fin && t_fin < 0) t_fin = cyc;
      if (t_fin >= 0) break;
    end
    check("fin_delay", 64'(t_fin - t_empty), 64'(FIN_DELAY));
    check("halt_entries", 64'(exp_q.size()), 64'd0);
    check("done_state", 64'(dbg_state), 64'(ST_DONE));
    @(posedge CLOCK); #1;
    redirect = 1'b1; redirect_pc = 32'h200;
    @(negedge CLOCK);
    check("done_redir_req", 64'(imem_req), 64'd0);
    @(posedge CLOCK); #1;
    redirect = 1'b0;
    repeat (3) @(negedge CLOCK);
    check("fin_sticky", 64'(fin), 64'd1);
    check("done_valid", 64'(out_valid), 64'd0);
    check("done_req", 64'(imem_req), 64'd0);
    check("done_hold", 64'(dbg_state), 64'(ST_DONE));
    out_ready = 1'b0;

    // halt, then redirect during DRAIN resumes fetching
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) expect_entry(32'(i * 4), 32'(i));
    for (int i = 0; i < 20; i++) begin
      @(negedge CLOCK);
      if (dbg_state == ST_DRAIN) break;
    end
    check("drain_reached", 64'(dbg_state), 64'(ST_DRAIN));
    @(posedge CLOCK); #1;
    redirect = 1'b1; redirect_pc = 32'h100;
    for (int i = 0; i < 3; i++) expect_entry(32'h100 + 32'(i * 4), 32'h40 + 32'(i));
    @(posedge CLOCK); #1;
    redirect = 1'b0;
    @(negedge CLOCK);
    check("resume_state", 64'(dbg_state), 64'(ST_RUN));
    check("resume_req", 64'(imem_req), 64'd1);
    check("resume_addr", 64'(imem_addr), 64'h100);
    check("resume_fin", 64'(fin), 64'd0);
    wait_drain(40);
    repeat (12) @(negedge CLOCK);
    check("resume_fin_late", 64'(fin), 64'd0);
    check("resume_state_late", 64'(dbg_state), 64'(ST_RUN));

    // one-cycle reset mid-stream with a full queue
    halt_en = 1'b0;
    do_reset(1'b0);
    repeat (8) @(negedge CLOCK);
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    check("pre_rst_fetched", 64'(stat_fetched), STATS_ON ? 64'd4 : 64'd0);
    @(posedge CLOCK); #1;
    RESET_N = 1'b0;
    @(posedge CLOCK); #1;
    RESET_N = 1'b1;
    @(negedge CLOCK);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_fin", 64'(fin), 64'd0);
    check("mid_rst_req", 64'(imem_req), 64'd1);
    check("mid_rst_addr", 64'(imem_addr), 64'(RESET_PC));
    check("mid_rst_fetched", 64'(stat_fetched), 64'd0);
    check("mid_rst_flushed", 64'(stat_flushed), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
